cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling controller for the direct-mapped cache: 128 lines, 8 words per line, 16-bit byte addresses, 2-byte words.
- On a miss, it issues eight sequential word reads to the multi-cycle main memory.
- As each word returns, it steers the word into the data array by line and word index.
- After the eighth word, it updates the tag array.
- Binary index outputs drive the 7-to-128 line decoder and 3-to-8 word decoder, which sit outside this block.

Parameters:
ADDR_W, 16, byte-address width.
INDEX_W, 7, line-index width; 128 lines, address bits [10:4].
WORD_W, 3, word-offset width; 8 words per line, address bits [3:1].

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
miss_detected  input  1  cache lookup missed this cycle.
miss_address  input  ADDR_W  byte address of the missing access; valid when miss_detected=1.
memory_data_valid  input  1  memory returns one word this cycle, in request order.
fsm_busy  output  1  fill in progress; the pipeline stalls while high.
mem_read_en  output  1  read request to memory this cycle.
memory_address  output  ADDR_W  address of the current read request.
write_data_array  output  1  write the returning word into the data array this cycle.
write_tag_array  output  1  write the tag and valid bit for the filled line this cycle.
line_index  output  INDEX_W  line being filled; goes to the 7-to-128 decoder.
word_index  output  WORD_W  word being written; goes to the 3-to-8 decoder.

Behaviour:
- Registered state:
  - state: IDLE or FILL.
  - blk_addr[15:4]: latched line address.
  - issue_cnt[3:0]: requests issued, 0..8.
  - recv_cnt[2:0]: words received, 0..7.
- Reset (async, rst=1):
  - state=IDLE; blk_addr=0; issue_cnt=0; recv_cnt=0.
  - All outputs 0, given miss_detected=0.
- Output logic:
  - Outputs are combinational from state, counters and inputs.
  - line_index = blk_addr[10:4] at all times.
- IDLE:
  - fsm_busy = miss_detected. The stall is asserted in the same cycle the miss is detected.
  - On miss_detected=1: latch blk_addr = miss_address[15:4], clear both counters, go to FILL next cycle.
  - memory_data_valid is ignored in IDLE. No writes occur.
- FILL:
  - fsm_busy=1 on every cycle.
  - Requests:
    - mem_read_en = (issue_cnt<8).
    - memory_address = {blk_addr, issue_cnt[2:0], 1'b0}.
    - Each cycle with mem_read_en=1 increments issue_cnt.
    - Requests are back-to-back: exactly 8 consecutive request cycles, first-word offset 0 regardless of the missing word.
  - Returns:
    - write_data_array = memory_data_valid & (recv_cnt < issue_cnt). A valid with no outstanding request is ignored.
    - word_index = recv_cnt.
    - Each accepted word increments recv_cnt.
  - Completion:
    - When an accepted word has recv_cnt=7, write_tag_array=1 in that same cycle.
    - The next state is IDLE and the counters clear.
  - miss_detected is ignored while in FILL; the pipeline is stalled.
- Timing:
  - With memory latency L (valid L cycles after the request), the fill takes 8+L cycles in FILL.
  - One extra IDLE cycle follows before the next miss can be accepted.
- Simultaneous request and return in one cycle are legal; both counters update independently.
- Reset mid-fill:
  - Immediately aborts to IDLE.
  - No tag write occurs.
  - Partially written data words are left in the array, harmless because the line's valid bit was not set.
- Width rules:
  - issue_cnt saturates at 8; it is never incremented past 8.
  - recv_cnt wraps to 0 only via the completion transition.

Test Plan:
1. Reset with rst=1 while miss_detected=0 -> all outputs 0; release rst, idle 5 cycles -> no mem_read_en, no writes.
2. miss_detected=1, miss_address=16'h1A36, memory latency 4 ->
   - fsm_busy=1 in the same cycle.
   - Next 8 cycles: memory_address=1A30,1A32,…,1A3E with mem_read_en=1.
   - line_index=7'h23 throughout.
   - write_data_array pulses 8 times with word_index 0..7.
   - write_tag_array=1 together with word 7; IDLE follows; fsm_busy low one cycle later.
3. Memory with gaps (valid stalls 2 cycles between words 3 and 4) -> exactly 8 data writes, word_index in order, tag write only on the 8th.
4. memory_data_valid pulsed in IDLE, and on the first FILL cycle before any request -> ignored, no write_data_array.
5. rst asserted after the 5th returned word -> immediate IDLE, no write_tag_array; a new miss at 16'h0000 -> full fill at line_index 0.
6. Back-to-back misses: second miss_detected in the first cycle after completion -> accepted. miss_detected held high during a fill -> no re-latch; the address stays at the first miss.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Purpose: miss-handling controller for the 128-line x 8-word direct-mapped cache fill.
// Latency: stall raised combinationally on the miss cycle; a fill spends 8+L cycles in FILL.
// Backpressure: fsm_busy stalls the pipeline; returns are accepted only against outstanding requests.
module cache_fill_fsm #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 7,
  parameter int WORD_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  input  logic                memory_data_valid,
  output logic                fsm_busy,
  output logic                mem_read_en,
  output logic [ADDR_W-1:0]   memory_address,
  output logic                write_data_array,
  output logic                write_tag_array,
  output logic [INDEX_W-1:0]  line_index,
  output logic [WORD_W-1:0]   word_index
);

  // Line address keeps everything above the word offset and byte bit.
  localparam int BLK_W = ADDR_W - WORD_W - 1;
  // Issue counter needs one extra bit to represent "all words requested".
  localparam int CNT_W = WORD_W + 1;
  localparam logic [CNT_W-1:0]  WORDS_PER_LINE = CNT_W'(1 << WORD_W);
  localparam logic [CNT_W-1:0]  ISSUE_ONE      = CNT_W'(1);
  localparam logic [WORD_W-1:0] RECV_ONE       = WORD_W'(1);
  localparam logic [WORD_W-1:0] LAST_WORD      = '1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [BLK_W-1:0]    blk_addr_q, blk_addr_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0]   recv_cnt_q, recv_cnt_d;

  // State and counter registers; reset aborts any fill in progress without a tag write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_addr_q  <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      blk_addr_q  <= blk_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Next state: latch the line on a miss, then count requests and returns until the last word lands.
  always_comb begin
    state_d     = state_q;
    blk_addr_d  = blk_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          blk_addr_d  = miss_address[ADDR_W-1:WORD_W+1];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      FILL: begin
        // Request and return may coincide; the two counters move independently.
        if (mem_read_en) begin
          issue_cnt_d = issue_cnt_q + ISSUE_ONE;
        end
        if (write_data_array) begin
          recv_cnt_d = recv_cnt_q + RECV_ONE;
        end
        if (write_tag_array) begin
          state_d     = IDLE;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: requests walk the line from word 0; returns are steered by the receive count.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    line_index       = blk_addr_q[INDEX_W-1:0];
    word_index       = recv_cnt_q;
    case (state_q)
      IDLE: begin
        // Stall in the very cycle the miss is seen so the missing access is held.
        fsm_busy = miss_detected;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_read_en      = (issue_cnt_q < WORDS_PER_LINE);
        memory_address   = {blk_addr_q, issue_cnt_q[WORD_W-1:0], 1'b0};
        // A valid with nothing outstanding (e.g. before the first request) is dropped.
        write_data_array = memory_data_valid && ({1'b0, recv_cnt_q} < issue_cnt_q);
        write_tag_array  = write_data_array && (recv_cnt_q == LAST_WORD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Purpose: directed self-checking bench for cache_fill_fsm with a fixed-latency in-order memory.
// Latency: memory returns each request a set number of cycles later, optionally with an inserted gap.
// Backpressure: none modelled beyond the fill controller's own stall output.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [6:0]  line_index;
  logic [2:0]  word_index;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .line_index        (line_index),
    .word_index        (word_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle with no miss: nothing may be requested or written.
  task automatic idle_check(input string tag, input logic [6:0] exp_line, input logic vld);
    step();
    miss_detected     = 1'b0;
    memory_data_valid = vld;
    #1;
    chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
    chk({tag, "_rd"},   32'(mem_read_en), 32'd0);
    chk({tag, "_addr"}, 32'(memory_address), 32'd0);
    chk({tag, "_wr"},   32'(write_data_array), 32'd0);
    chk({tag, "_tag"},  32'(write_tag_array), 32'd0);
    chk({tag, "_line"}, 32'(line_index), 32'(exp_line));
  endtask

  // Full fill: miss cycle, then per-cycle checks of requests, returns and completion.
  task automatic do_fill(input logic [15:0] addr, input int lat, input int gap_word,
                         input int gap_len, input int abort_after, input bit spurious,
                         input bit hold_miss);
    int          req_t[$];
    int          issued   = 0;
    int          recv     = 0;
    int          gap_left = gap_len;
    int          fill_cyc = 0;
    bit          done     = 0;
    bit          aborted  = 0;
    bit          v;
    logic [15:0] base;
    base = {addr[15:4], 4'h0};

    step();
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = spurious;
    #1;
    chk("miss_busy", 32'(fsm_busy), 32'd1);
    chk("miss_rd",   32'(mem_read_en), 32'd0);
    chk("miss_wr",   32'(write_data_array), 32'd0);
    chk("miss_tag",  32'(write_tag_array), 32'd0);

    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      step();
      fill_cyc++;
      v = 0;
      if (recv < req_t.size()) v = (req_t[recv] + lat <= cyc);
      if (v && recv == gap_word && gap_left > 0) begin
        v = 0;
        gap_left--;
      end
      miss_detected     = hold_miss;
      miss_address      = hold_miss ? 16'hFFFF : addr;
      memory_data_valid = v | (spurious && cyc == 1);
      #1;
      chk("fill_busy", 32'(fsm_busy), 32'd1);
      chk("fill_rd",   32'(mem_read_en), 32'(issued < 8));
      if (issued < 8) chk("fill_addr", 32'(memory_address), 32'(16'(base + 2 * issued)));
      chk("fill_line", 32'(line_index), 32'(addr[10:4]));
      chk("fill_wr",   32'(write_data_array), 32'(v));
      if (v) chk("fill_word", 32'(word_index), 32'(recv));
      chk("fill_tag",  32'(write_tag_array), 32'(v && recv == 7));
      if (issued < 8) begin
        req_t.push_back(cyc);
        issued++;
      end
      if (v) recv++;
      if (recv == 8) done = 1;
      if (!done && abort_after > 0 && recv == abort_after) begin
        step();
        rst               = 1'b1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        #1;
        chk("abort_busy", 32'(fsm_busy), 32'd0);
        chk("abort_rd",   32'(mem_read_en), 32'd0);
        chk("abort_wr",   32'(write_data_array), 32'd0);
        chk("abort_tag",  32'(write_tag_array), 32'd0);
        chk("abort_line", 32'(line_index), 32'd0);
        rst     = 1'b0;
        done    = 1;
        aborted = 1;
      end
    end
    if (!done) chk("fill_timeout", 32'd0, 32'd1);
    if (!aborted) begin
      chk("fill_len",   32'(fill_cyc), 32'(8 + lat + gap_len));
      chk("fill_words", 32'(recv), 32'd8);
    end
  endtask

  initial begin
    rst               = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy",  32'(fsm_busy), 32'd0);
    chk("rst_rd",    32'(mem_read_en), 32'd0);
    chk("rst_addr",  32'(memory_address), 32'd0);
    chk("rst_wr",    32'(write_data_array), 32'd0);
    chk("rst_tag",   32'(write_tag_array), 32'd0);
    chk("rst_line",  32'(line_index), 32'd0);
    chk("rst_word",  32'(word_index), 32'd0);
    #4 rst = 1'b0;
    for (int i = 0; i < 5; i++) idle_check("idle", 7'h00, 1'b0);

    // Basic fill, latency 4, missing word in the middle of the line.
    do_fill(16'h1A36, 4, -1, 0, 0, 0, 0);
    idle_check("post_fill", 7'h23, 1'b0);

    // Memory stalls two cycles before word index 3.
    do_fill(16'h5C8A, 3, 3, 2, 0, 0, 0);
    idle_check("post_gap", 7'h48, 1'b0);

    // Stray valids in IDLE and on the first FILL cycle are dropped.
    idle_check("idle_vld", 7'h48, 1'b1);
    do_fill(16'h0F5E, 2, -1, 0, 0, 1, 0);
    idle_check("post_spur", 7'h75, 1'b0);

    // Reset after the fifth word, then a fresh fill of line 0.
    do_fill(16'h7FF2, 4, -1, 0, 5, 0, 0);
    idle_check("post_abort", 7'h00, 1'b0);
    do_fill(16'h0000, 4, -1, 0, 0, 0, 0);
    idle_check("post_zero", 7'h00, 1'b0);

    // Miss held through a fill, then a second miss right after completion.
    do_fill(16'h1234, 1, -1, 0, 0, 0, 1);
    do_fill(16'hBEEE, 5, -1, 0, 0, 0, 0);
    idle_check("post_b2b", 7'h6E, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
